// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and port-select encoding for the regfile write-port arbiter.
package wb_port_arbiter_pkg;
  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_WB   = 2'd1,
    SEL_FIFO = 2'd2,
    SEL_BYP  = 2'd3
  } wsel_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// WB/MDU/regfile/decode signals of the write-port arbiter.
// slave = arbiter side, master = surrounding pipeline.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW = XLEN,
  parameter int AW = REG_AW
);
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_wd;
  logic          mdu_valid;
  logic [AW-1:0] mdu_rd;
  logic [DW-1:0] mdu_wd;
  logic          mdu_ready;
  logic [AW-1:0] query_rd;
  logic          pending;
  logic          wb_stall_req;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  modport slave (
    input  wb_valid, wb_rd, wb_wd, mdu_valid, mdu_rd, mdu_wd, query_rd,
    output mdu_ready, pending, wb_stall_req, rf_we, rf_wa, rf_wd
  );
  modport master (
    output wb_valid, wb_rd, wb_wd, mdu_valid, mdu_rd, mdu_wd, query_rd,
    input  mdu_ready, pending, wb_stall_req, rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/wb_fifo.sv
// In-order MDU result FIFO (power-of-2 DEPTH). Exposes every slot's rd tag
// plus a per-slot valid mask so the arbiter can do the pending-rd lookup.
module wb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW    = XLEN,
  parameter int AW    = REG_AW,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [AW-1:0]       push_rd,
  input  logic [DW-1:0]       push_wd,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output logic [AW-1:0]       head_rd,
  output logic [DW-1:0]       head_wd,
  output logic [DEPTH*AW-1:0] tag_vec,
  output logic [DEPTH-1:0]    tag_vld
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] rd_mem_q, rd_mem_d;
  logic [DEPTH-1:0][DW-1:0] wd_mem_q, wd_mem_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head_rd = rd_mem_q[rd_ptr_q];
  assign head_wd = wd_mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    rd_mem_d = rd_mem_q;
    wd_mem_d = wd_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      rd_mem_d[wr_ptr_q] = push_rd;
      wd_mem_d[wr_ptr_q] = push_wd;
      wr_ptr_d           = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Slot i is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_tag
    logic [PW-1:0] off;
    assign off                  = PW'(i) - rd_ptr_q;
    assign tag_vld[i]           = (CW'(off) < cnt_q);
    assign tag_vec[i*AW +: AW]  = rd_mem_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_mem_q <= '0;
      wd_mem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_mem_q <= rd_mem_d;
      wd_mem_q <= wd_mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between pipeline WB (absolute priority) and
// queued MDU results. WBARB_BYPASS_EN enables same-cycle MDU writes when idle.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW           = XLEN,
  parameter int AW           = REG_AW,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                full, empty, wb_take, slot_free, pop, push, byp, pend;
  logic [AW-1:0]       head_rd, rf_wa;
  logic [DW-1:0]       head_wd, rf_wd;
  logic                rf_we;
  logic [DEPTH*AW-1:0] tag_vec;
  logic [DEPTH-1:0]    tag_vld;
  logic [SW-1:0]       starve_cnt_q, starve_cnt_d;
  logic                stall_q, stall_d;
  wsel_e               sel;

  wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_rd (bus.mdu_rd),
    .push_wd (bus.mdu_wd),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head_rd (head_rd),
    .head_wd (head_wd),
    .tag_vec (tag_vec),
    .tag_vld (tag_vld)
  );

  // An x0 write from WB is a free slot: it is dropped and the FIFO may drain.
  always_comb begin
    wb_take   = bus.wb_valid && (bus.wb_rd != '0);
    slot_free = !wb_take;
    pop       = slot_free && !empty;
`ifdef WBARB_BYPASS_EN
    byp       = slot_free && empty && bus.mdu_valid;
`else
    byp       = 1'b0;
`endif
    push      = bus.mdu_valid && !full && !byp;
    if (wb_take)     sel = SEL_WB;
    else if (!empty) sel = SEL_FIFO;
    else if (byp)    sel = SEL_BYP;
    else             sel = SEL_NONE;
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    case (sel)
      SEL_WB:   begin rf_we = 1'b1;             rf_wa = bus.wb_rd;  rf_wd = bus.wb_wd;  end
      SEL_FIFO: begin rf_we = (head_rd != '0);  rf_wa = head_rd;    rf_wd = head_wd;    end
      SEL_BYP:  begin rf_we = (bus.mdu_rd != '0); rf_wa = bus.mdu_rd; rf_wd = bus.mdu_wd; end
      default:  ;
    endcase
    if (rst) rf_we = 1'b0;
  end

  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      pend |= tag_vld[i] && (tag_vec[i*AW +: AW] == bus.query_rd);
    if (bus.query_rd == '0) pend = 1'b0;
  end

  always_comb begin
    if (empty || pop)                          starve_cnt_d = '0;
    else if (starve_cnt_q != SW'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + 1'b1;
    else                                       starve_cnt_d = starve_cnt_q;
    stall_d = (starve_cnt_q >= SW'(STARVE_LIMIT - 1)) && !pop && !empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      stall_q      <= stall_d;
    end
  end

  assign bus.mdu_ready    = !full;
  assign bus.pending      = pend;
  assign bus.wb_stall_req = stall_q;
  assign bus.rf_we        = rf_we;
  assign bus.rf_wa        = rf_wa;
  assign bus.rf_wd        = rf_wd;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Table-driven bench for wb_port_arbiter with an MDU retirement scoreboard.
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DW(32), .AW(5)) bus ();

  wb_port_arbiter #(.DW(32), .AW(5), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wwd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mwd;
    logic [4:0]  q;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_pend;
    logic        e_stall;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  int   n_pass = 0;
  int   n_tot  = 0;
  ent_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(logic wv, logic [4:0] wrd, logic [31:0] wwd,
                              logic mv, logic [4:0] mrd, logic [31:0] mwd, logic [4:0] q,
                              logic e_we, logic [4:0] e_wa, logic [31:0] e_wd,
                              logic e_rdy, logic e_pend, logic e_stall);
    vec_t v;
    v.wv = wv;  v.wrd = wrd;  v.wwd = wwd;
    v.mv = mv;  v.mrd = mrd;  v.mwd = mwd;  v.q = q;
    v.e_we = e_we;  v.e_wa = e_wa;  v.e_wd = e_wd;
    v.e_rdy = e_rdy;  v.e_pend = e_pend;  v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle, check at negedge, then let the rising edge commit.
  task automatic cyc(input vec_t v, input string tag);
    ent_t e;
    bus.wb_valid  = v.wv;  bus.wb_rd  = v.wrd;  bus.wb_wd  = v.wwd;
    bus.mdu_valid = v.mv;  bus.mdu_rd = v.mrd;  bus.mdu_wd = v.mwd;
    bus.query_rd  = v.q;
    @(negedge clk);
    if (v.mv && v.e_rdy && v.mrd != 5'd0) begin
      e.rd = v.mrd;  e.wd = v.mwd;
      sb.push_back(e);
    end
    chk({tag, ".rf_we"}, 32'(bus.rf_we), 32'(v.e_we));
    if (v.e_we) begin
      chk({tag, ".rf_wa"}, 32'(bus.rf_wa), 32'(v.e_wa));
      chk({tag, ".rf_wd"}, bus.rf_wd, v.e_wd);
    end
    chk({tag, ".mdu_ready"}, 32'(bus.mdu_ready), 32'(v.e_rdy));
    chk({tag, ".pending"}, 32'(bus.pending), 32'(v.e_pend));
    chk({tag, ".stall"}, 32'(bus.wb_stall_req), 32'(v.e_stall));
    if (bus.rf_we && !(v.wv && v.wrd != 5'd0)) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL %s.sb: unexpected MDU write rd=%0d wd=0x%0h, want none", tag, bus.rf_wa, bus.rf_wd);
      end else begin
        e = sb.pop_front();
        chk({tag, ".sb_rd"}, 32'(bus.rf_wa), 32'(e.rd));
        chk({tag, ".sb_wd"}, bus.rf_wd, e.wd);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with an MDU result on offer.
    bus.wb_valid = 1'b0;  bus.wb_rd = '0;  bus.wb_wd = '0;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd3; bus.mdu_wd = 32'h3333;
    bus.query_rd = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst.mdu_ready", 32'(bus.mdu_ready), 32'd1);
    chk("rst.pending", 32'(bus.pending), 32'd0);
    chk("rst.stall", 32'(bus.wb_stall_req), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mdu_valid = 1'b0;

    //                wv wrd  wwd        mv mrd  mwd        q     we wa   wd         rdy pnd stl
    tbl.push_back(mk(0, 0,  0,         0, 0,  0,         5'd3, 0, 0,  0,         1,  0,  0)); // nothing kept from reset
    // WB wins over a same-cycle MDU result, which retires on the next free slot
    tbl.push_back(mk(1, 5,  32'hAAAA,  1, 6,  32'hBBBB,  5'd6, 1, 5,  32'hAAAA,  1,  0,  0));
    tbl.push_back(mk(0, 0,  0,         0, 0,  0,         5'd6, 1, 6,  32'hBBBB,  1,  1,  0));
    tbl.push_back(mk(0, 0,  0,         0, 0,  0,         5'd6, 0, 0,  0,         1,  0,  0));
    // Fill under continuous WB; the 5th result is held while full
    tbl.push_back(mk(1, 1,  32'h11,    1, 10, 32'hA0,    5'd0, 1, 1,  32'h11,    1,  0,  0));
    tbl.push_back(mk(1, 2,  32'h22,    1, 11, 32'hA1,    5'd0, 1, 2,  32'h22,    1,  0,  0));
    tbl.push_back(mk(1, 3,  32'h33,    1, 12, 32'hA2,    5'd0, 1, 3,  32'h33,    1,  0,  0));
    tbl.push_back(mk(1, 4,  32'h44,    1, 13, 32'hA3,    5'd0, 1, 4,  32'h44,    1,  0,  0));
    tbl.push_back(mk(1, 1,  32'h55,    1, 14, 32'hA4,    5'd14,1, 1,  32'h55,    0,  0,  0));
    tbl.push_back(mk(0, 0,  0,         1, 14, 32'hA4,    5'd10,1, 10, 32'hA0,    0,  1,  0));
    tbl.push_back(mk(0, 0,  0,         1, 14, 32'hA4,    5'd0, 1, 11, 32'hA1,    1,  0,  0));
    tbl.push_back(mk(0, 0,  0,         0, 0,  0,         5'd0, 1, 12, 32'hA2,    1,  0,  0));
    tbl.push_back(mk(0, 0,  0,         0, 0,  0,         5'd0, 1, 13, 32'hA3,    1,  0,  0));
    tbl.push_back(mk(0, 0,  0,         0, 0,  0,         5'd14,1, 14, 32'hA4,    1,  1,  0));
    tbl.push_back(mk(0, 0,  0,         0, 0,  0,         5'd14,0, 0,  0,         1,  0,  0));
    // x0 entries never write; x0 WB writes free the slot
    tbl.push_back(mk(1, 8,  32'h88,    1, 0,  32'hD0,    5'd0, 1, 8,  32'h88,    1,  0,  0));
    tbl.push_back(mk(1, 9,  32'h99,    1, 7,  32'hD7,    5'd7, 1, 9,  32'h99,    1,  0,  0));
    tbl.push_back(mk(1, 8,  32'h8,     0, 0,  0,         5'd7, 1, 8,  32'h8,     1,  1,  0));
    tbl.push_back(mk(1, 9,  32'h9,     0, 0,  0,         5'd0, 1, 9,  32'h9,     1,  0,  0));
    tbl.push_back(mk(1, 0,  32'hEE,    0, 0,  0,         5'd7, 0, 0,  0,         1,  1,  0));
    tbl.push_back(mk(1, 0,  32'hEF,    0, 0,  0,         5'd7, 1, 7,  32'hD7,    1,  1,  0));
    tbl.push_back(mk(0, 0,  0,         0, 0,  0,         5'd7, 0, 0,  0,         1,  0,  0));

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], $sformatf("r%0d", i));

    // Starvation: one queued entry behind back-to-back WB writes
    cyc(mk(1, 1, 32'h111, 1, 20, 32'hC0, 5'd0, 1, 1, 32'h111, 1, 0, 0), "st.push");
    for (int j = 0; j < 8; j++)
      cyc(mk(1, 2, 32'h200 + j, 0, 0, 0, 5'd0, 1, 2, 32'h200 + j, 1, 0, 0), $sformatf("st.h%0d", j));
    cyc(mk(1, 2, 32'h2F0, 0, 0, 0, 5'd0, 1, 2, 32'h2F0, 1, 0, 1), "st.req");
    cyc(mk(1, 2, 32'h2F1, 0, 0, 0, 5'd0, 1, 2, 32'h2F1, 1, 0, 1), "st.sat");
    cyc(mk(0, 0, 0,       0, 0, 0, 5'd20, 1, 20, 32'hC0, 1, 1, 1), "st.bubble");
    cyc(mk(0, 0, 0,       0, 0, 0, 5'd20, 0, 0, 0,       1, 0, 0), "st.clear");

`ifdef WBARB_BYPASS_EN
    cyc(mk(0, 0, 0, 1, 9, 32'h1234, 5'd9, 1, 9, 32'h1234, 1, 0, 0), "byp.hit");
    cyc(mk(0, 0, 0, 0, 0, 0,        5'd9, 0, 0, 0,        1, 0, 0), "byp.noq");
`else
    cyc(mk(0, 0, 0, 1, 9, 32'h1234, 5'd9, 0, 0, 0,        1, 0, 0), "nb.accept");
    cyc(mk(0, 0, 0, 0, 0, 0,        5'd9, 1, 9, 32'h1234, 1, 1, 0), "nb.retire");
    cyc(mk(0, 0, 0, 0, 0, 0,        5'd9, 0, 0, 0,        1, 0, 0), "nb.idle");
`endif

    n_tot++;
    if (sb.size() != 0) $display("FAIL sb.drain: got %0d entries left, want 0", sb.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
